// File: rtl/lemon_ifu.sv
// Instruction fetch unit: owns the fetch PC, issues one outstanding request at a time, buffers {pc, inst} for decode.
// Optional feature: define IFU_MISALIGN_CHECK_EN to fault on misaligned redirects; otherwise redirect_pc[1:0] is forced to 0.
module lemon_ifu #(
    parameter int unsigned       ADDR_W  = 64,
    parameter int unsigned       INST_W  = 32,
    parameter logic [ADDR_W-1:0] PC_INIT = ADDR_W'(64'h8000_0000),
    parameter int unsigned       DEPTH   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [63:0]       mem_resp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [INST_W-1:0] inst,
    output logic              fetch_fault
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  count, count_after;
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic              fault;
    logic              accept, enq, deq, bad_redirect;
    logic [ADDR_W-1:0] redirect_tgt;
    logic [31:0]       inst_word;

`ifdef IFU_MISALIGN_CHECK_EN
    assign bad_redirect = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign redirect_tgt = redirect_pc;
`else
    assign bad_redirect = 1'b0;
    assign redirect_tgt = redirect_pc & ~ADDR_W'(3);
`endif

    assign mem_req_valid = (state == REQ);
    assign mem_req_addr  = {pc[ADDR_W-1:3], 3'b000};
    assign accept        = mem_req_valid && mem_req_ready;
    assign enq           = (state == WAIT) && mem_resp_valid && !redirect_valid;
    assign inst_valid    = (count != '0);
    assign deq           = inst_valid && inst_ready;
    assign count_after   = count + CNT_W'(enq) - CNT_W'(deq);
    assign inst_word     = pc[2] ? mem_resp_data[63:32] : mem_resp_data[31:0];
    assign inst_pc       = pc_mem[rd_ptr];
    assign inst          = inst_mem[rd_ptr];
    assign fetch_fault   = fault;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (count < CNT_W'(DEPTH)) state_nxt = REQ;
            REQ:  if (accept) state_nxt = WAIT;
            WAIT: if (mem_resp_valid) state_nxt = (count_after < CNT_W'(DEPTH)) ? REQ : IDLE;
            DROP: if (mem_resp_valid) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
        // A redirect must still wait out any response already owed by memory.
        if (redirect_valid) begin
            if ((state == WAIT || state == DROP) && !mem_resp_valid)
                state_nxt = DROP;
            else if (state == REQ && accept)
                state_nxt = DROP;
            else
                state_nxt = REQ;
        end
        if (fault || bad_redirect) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            pc     <= PC_INIT;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            fault  <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            fault <= fault || bad_redirect;
            if (redirect_valid) begin
                pc     <= redirect_tgt;
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (enq) begin
                    pc_mem[wr_ptr]   <= pc;
                    inst_mem[wr_ptr] <= INST_W'(inst_word);
                    wr_ptr           <= wr_ptr + 1'b1;
                    pc               <= pc + ADDR_W'(4);
                end
                if (deq) rd_ptr <= rd_ptr + 1'b1;
                count <= count_after;
            end
        end
    end

endmodule

// File: tb/tb_lemon_ifu.sv
// Randomized bench for lemon_ifu: a memory responder plus an in-order fetch-stream model checked per consumed instruction.
module tb_lemon_ifu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        mem_req_valid;
    logic [63:0] mem_req_addr;
    logic        mem_req_ready = 1'b0;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_resp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [63:0] inst_pc;
    logic [31:0] inst;
    logic        fetch_fault;

    lemon_ifu #(
        .ADDR_W (64),
        .INST_W (32),
        .PC_INIT(64'h8000_0000),
        .DEPTH  (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_pc       (inst_pc),
        .inst          (inst),
        .fetch_fault   (fetch_fault)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int cyc = 0;
    int p_ready, p_ir, lat_min, lat_max;
    bit pend;
    int pend_cnt;
    logic [63:0] pend_addr;
    logic [63:0] acc_q[$];
    int n_resp, n_cons, first_resp_cyc;
    logic [63:0] exp_pc;
    bit halted;
    bit redir_req, redir_on_resp;
    logic [63:0] redir_tgt;

    // Memory image: each aligned 64-bit word is a fixed function of its address.
    function automatic logic [63:0] word_of(input logic [63:0] a);
        return {a[31:0] ^ a[63:32] ^ 32'hC0DE_5A5A, ~a[31:0] + a[63:32]};
    endfunction

    function automatic logic [31:0] model_inst(input logic [63:0] p);
        logic [63:0] w;
        w = word_of({p[63:3], 3'b000});
        return p[2] ? w[63:32] : w[31:0];
    endfunction

    // One clock: memory responder, decode consumer and scoreboard, redirect driver.
    task automatic cycle();
        bit resp_now;
        @(negedge clk);
        cyc++;
        if (mem_req_valid) begin
            n_tests++;
            if (pend) begin
                n_fail++;
                $display("FAIL one_outstanding: req_valid=1 while response owed (addr %h)", pend_addr);
            end
        end
        resp_now       = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = {$urandom(), $urandom()};
        if (pend) begin
            pend_cnt--;
            if (pend_cnt <= 0) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = word_of(pend_addr);
                pend           = 1'b0;
                resp_now       = 1'b1;
                n_resp++;
                if (n_resp == 1) first_resp_cyc = cyc;
            end
        end
        mem_req_ready = ($urandom_range(99) < p_ready);
        if (mem_req_valid && mem_req_ready) begin
            pend      = 1'b1;
            pend_cnt  = $urandom_range(lat_max, lat_min);
            pend_addr = mem_req_addr;
            acc_q.push_back(mem_req_addr);
            n_tests++;
            if (mem_req_addr[2:0] != 3'b000) begin
                n_fail++;
                $display("FAIL req_align: addr %h not 8-byte aligned", mem_req_addr);
            end
        end
        inst_ready = ($urandom_range(99) < p_ir);
        if (inst_valid && inst_ready) begin
            n_cons++;
            if (halted) begin
                n_tests++;
                n_fail++;
                $display("FAIL consume_after_fault: got pc %h, want nothing", inst_pc);
            end else begin
                n_tests += 2;
                if (inst_pc !== exp_pc) begin
                    n_fail++;
                    $display("FAIL inst_pc: got %h want %h", inst_pc, exp_pc);
                end
                if (inst !== model_inst(exp_pc)) begin
                    n_fail++;
                    $display("FAIL inst_data: pc %h got %h want %h", exp_pc, inst, model_inst(exp_pc));
                end
                exp_pc = exp_pc + 64'd4;
            end
        end
        redirect_valid = 1'b0;
        if (redir_req || (redir_on_resp && resp_now)) begin
            redirect_valid = 1'b1;
            redirect_pc    = redir_tgt;
            redir_req      = 1'b0;
            redir_on_resp  = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
            if (redir_tgt[1:0] != 2'b00) halted = 1'b1;
            else exp_pc = redir_tgt;
`else
            exp_pc = redir_tgt & ~64'd3;
`endif
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        inst_ready     = 1'b0;
        pend           = 1'b0;
        acc_q.delete();
        n_resp         = 0;
        n_cons         = 0;
        first_resp_cyc = -1;
        exp_pc         = 64'h8000_0000;
        halted         = 1'b0;
        redir_req      = 1'b0;
        redir_on_resp  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        inst_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_tests += 5;
        if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b want 0", mem_req_valid); end
        if (inst_valid !== 1'b0)    begin n_fail++; $display("FAIL rst_inst_valid: got %b want 0", inst_valid); end
        if (inst_pc !== 64'd0)      begin n_fail++; $display("FAIL rst_inst_pc: got %h want 0", inst_pc); end
        if (inst !== 32'd0)         begin n_fail++; $display("FAIL rst_inst: got %h want 0", inst); end
        if (fetch_fault !== 1'b0)   begin n_fail++; $display("FAIL rst_fault: got %b want 0", fetch_fault); end
        do_reset();
        p_ready = 100; p_ir = 0; lat_min = 1; lat_max = 1;
        n_tests++;
        if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: got %b want 0", mem_req_valid); end
        cycle();
        n_tests += 2;
        if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b want 1", mem_req_valid); end
        if (acc_q.size() != 1 || acc_q[0] !== 64'h8000_0000) begin
            n_fail++;
            $display("FAIL first_addr: got %0d accepts, want one at 80000000", acc_q.size());
        end
    endtask

    task automatic test_basic();
        logic [63:0] ea [3];
        bit seen;
        ea[0] = 64'h8000_0000; ea[1] = 64'h8000_0000; ea[2] = 64'h8000_0008;
        do_reset();
        p_ready = 100; p_ir = 100; lat_min = 1; lat_max = 1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !(n_cons >= 3 && acc_q.size() >= 3); i++) begin
            cycle();
            if (!seen && inst_valid) begin
                seen = 1'b1;
                n_tests++;
                if (cyc != first_resp_cyc + 1) begin
                    n_fail++;
                    $display("FAIL resp_to_valid: got cycle %0d want %0d", cyc, first_resp_cyc + 1);
                end
            end
        end
        n_tests++;
        if (n_cons < 3 || acc_q.size() < 3) begin
            n_fail++;
            $display("FAIL basic_progress: got %0d consumed %0d accepts want 3/3", n_cons, acc_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (acc_q[i] !== ea[i]) begin
                    n_fail++;
                    $display("FAIL basic_addr%0d: got %h want %h", i, acc_q[i], ea[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        p_ready = 100; p_ir = 0; lat_min = 1; lat_max = 1;
        repeat (12) cycle();
        n_tests += 3;
        if (n_resp != 2)            begin n_fail++; $display("FAIL bp_buffered: got %0d responses want 2", n_resp); end
        if (inst_valid !== 1'b1)    begin n_fail++; $display("FAIL bp_inst_valid: got %b want 1", inst_valid); end
        if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_stall: got req_valid %b want 0", mem_req_valid); end
        p_ir = 100;
        cycle();
        p_ir = 0;
        n_tests++;
        if (n_cons != 1) begin n_fail++; $display("FAIL bp_one_deq: got %0d consumed want 1", n_cons); end
        for (int i = 0; i < 3 && !mem_req_valid; i++) cycle();
        n_tests++;
        if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL bp_resume: got req_valid %b want 1", mem_req_valid); end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        p_ready = 100; p_ir = 0; lat_min = 3; lat_max = 3;
        for (int i = 0; i < 30 && acc_q.size() < 2; i++) cycle();
        redir_req = 1'b1; redir_tgt = 64'h8000_0100;
        cycle();
        cycle();
        n_tests += 2;
        if (inst_valid !== 1'b0)    begin n_fail++; $display("FAIL rw_flush: got inst_valid %b want 0", inst_valid); end
        if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rw_drop: got req_valid %b want 0", mem_req_valid); end
        for (int i = 0; i < 20 && acc_q.size() < 3; i++) cycle();
        n_tests += 2;
        if (acc_q.size() < 3 || acc_q[2] !== 64'h8000_0100) begin
            n_fail++;
            $display("FAIL rw_new_addr: got %0d accepts, want third at 80000100", acc_q.size());
        end
        if (n_resp != 2) begin n_fail++; $display("FAIL rw_drained: got %0d responses want 2", n_resp); end
        p_ir = 100;
        for (int i = 0; i < 20 && n_cons < 1; i++) cycle();
        n_tests++;
        if (n_cons < 1) begin n_fail++; $display("FAIL rw_progress: got %0d consumed want >=1", n_cons); end
    endtask

    task automatic test_redirect_resp();
        do_reset();
        p_ready = 100; p_ir = 0; lat_min = 2; lat_max = 2;
        for (int i = 0; i < 20 && n_resp < 1; i++) cycle();
        redir_on_resp = 1'b1; redir_tgt = 64'h8000_0204;
        for (int i = 0; i < 20 && redir_on_resp; i++) cycle();
        n_tests++;
        if (redir_on_resp) begin n_fail++; $display("FAIL rr_timeout: got no second response want one"); end
        cycle();
        n_tests += 3;
        if (inst_valid !== 1'b0)               begin n_fail++; $display("FAIL rr_flush: got inst_valid %b want 0", inst_valid); end
        if (mem_req_valid !== 1'b1)            begin n_fail++; $display("FAIL rr_req: got req_valid %b want 1", mem_req_valid); end
        if (mem_req_addr !== 64'h8000_0200)    begin n_fail++; $display("FAIL rr_addr: got %h want 80000200", mem_req_addr); end
        p_ir = 100;
        for (int i = 0; i < 20 && n_cons < 1; i++) cycle();
        n_tests++;
        if (n_cons < 1) begin n_fail++; $display("FAIL rr_progress: got %0d consumed want >=1", n_cons); end
    endtask

    task automatic test_misalign();
        int n0;
        do_reset();
        p_ready = 100; p_ir = 100; lat_min = 1; lat_max = 2;
        repeat (6) cycle();
        redir_req = 1'b1; redir_tgt = 64'h8000_0002;
        cycle();
`ifdef IFU_MISALIGN_CHECK_EN
        cycle();
        n_tests++;
        if (fetch_fault !== 1'b1) begin n_fail++; $display("FAIL ma_fault: got %b want 1", fetch_fault); end
        for (int i = 0; i < 10; i++) begin
            cycle();
            n_tests++;
            if (mem_req_valid !== 1'b0 || fetch_fault !== 1'b1) begin
                n_fail++;
                $display("FAIL ma_held: got req_valid %b fault %b want 0/1", mem_req_valid, fetch_fault);
            end
        end
        do_reset();
        n_tests++;
        if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL ma_reset_clears: got %b want 0", fetch_fault); end
`else
        n0 = acc_q.size();
        for (int i = 0; i < 20 && acc_q.size() <= n0; i++) cycle();
        n_tests += 2;
        if (acc_q.size() <= n0 || acc_q[n0] !== 64'h8000_0000) begin
            n_fail++;
            $display("FAIL ma_addr: got %0d accepts after redirect, want one at 80000000", acc_q.size() - n0);
        end
        if (fetch_fault !== 1'b0) begin n_fail++; $display("FAIL ma_nofault: got %b want 0", fetch_fault); end
        n0 = n_cons;
        for (int i = 0; i < 20 && n_cons <= n0; i++) cycle();
        n_tests++;
        if (n_cons <= n0) begin n_fail++; $display("FAIL ma_progress: got %0d consumed want >%0d", n_cons, n0); end
`endif
    endtask

    task automatic test_wrap();
        int n0, c0;
        do_reset();
        p_ready = 100; p_ir = 100; lat_min = 1; lat_max = 1;
        repeat (4) cycle();
        redir_req = 1'b1; redir_tgt = 64'hFFFF_FFFF_FFFF_FFFC;
        cycle();
        n0 = acc_q.size();
        c0 = n_cons;
        for (int i = 0; i < 30 && (acc_q.size() < n0 + 2 || n_cons < c0 + 2); i++) cycle();
        n_tests += 3;
        if (acc_q.size() < n0 + 2) begin
            n_fail++;
            $display("FAIL wrap_progress: got %0d accepts want 2", acc_q.size() - n0);
        end else begin
            if (acc_q[n0] !== 64'hFFFF_FFFF_FFFF_FFF8) begin n_fail++; $display("FAIL wrap_addr0: got %h want fffffffffffffff8", acc_q[n0]); end
            if (acc_q[n0+1] !== 64'd0) begin n_fail++; $display("FAIL wrap_addr1: got %h want 0", acc_q[n0+1]); end
        end
        n_tests++;
        if (n_cons < c0 + 2) begin n_fail++; $display("FAIL wrap_consume: got %0d consumed want 2", n_cons - c0); end
    endtask

    task automatic test_random();
        do_reset();
        lat_min = 1; lat_max = 3;
        for (int i = 0; i < 600; i++) begin
            if (i % 100 == 0) begin
                p_ready = $urandom_range(100, 30);
                p_ir    = $urandom_range(100, 20);
            end
            if (!redir_req && !redir_on_resp && $urandom_range(99) < 3) begin
                redir_tgt = {32'h0, 32'h8000_0000 | ($urandom() & 32'h0000_FFFC)};
                if ($urandom_range(1) == 1) redir_on_resp = 1'b1;
                else redir_req = 1'b1;
            end
            cycle();
        end
        n_tests++;
        if (n_cons < 30) begin n_fail++; $display("FAIL rand_progress: got %0d consumed want >=30", n_cons); end
    endtask

    initial begin
        p_ready = 0; p_ir = 0; lat_min = 1; lat_max = 1;
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect_wait();
        test_redirect_resp();
        test_misalign();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
